// File: rtl/seven_seg_pkg.sv
// Shared constants and digit-index type for the 7-segment scanner and decoder.
package seven_seg_pkg;

    localparam int SEG_W      = 7;
    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 8;
    localparam int IDX_W      = $clog2(MAX_DIGITS);

    typedef logic [IDX_W-1:0] digit_idx_t;

    function automatic digit_idx_t next_idx(input digit_idx_t idx, input digit_idx_t last);
        if (idx == last) begin
            return digit_idx_t'(0);
        end else begin
            return idx + digit_idx_t'(1);
        end
    endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Free-running slot prescaler: counts 0..REFRESH_DIV-1 and flags the wrap cycle.
module seven_seg_prescaler #(
    parameter int REFRESH_DIV = 50000,
    localparam int PRE_W      = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [PRE_W-1:0] count,
    output logic             tick
);

    logic [PRE_W-1:0] count_r;

    assign tick  = (count_r == PRE_W'(REFRESH_DIV - 1));
    assign count = count_r;

    // Prescaler counter, wraps to zero on the tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {PRE_W{1'b0}};
        end else if (tick) begin
            count_r <= {PRE_W{1'b0}};
        end else begin
            count_r <= count_r + PRE_W'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with frame-aligned value updates.
// Optional leading-zero blanking: define SEVEN_SEG_SCANNER_BLANK_LEADING_ZEROS_EN.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NIBBLE_W*DIGITS-1:0] value_i,
    input  logic                       load_i,
    output logic                       pending_o,
    output logic [NIBBLE_W-1:0]        nibble_o,
    output logic [DIGITS-1:0]          digit_n_o,
    output logic                       frame_o
);

    localparam int         PRE_W    = $clog2(REFRESH_DIV);
    localparam digit_idx_t LAST_IDX = digit_idx_t'(DIGITS - 1);

    logic [PRE_W-1:0]           pre_s;
    logic                       tick_s;
    logic                       boundary_s;
    logic                       guard_s;
    digit_idx_t                 idx_r;
    logic [NIBBLE_W*DIGITS-1:0] active_r;
    logic [NIBBLE_W*DIGITS-1:0] shadow_r;
    logic                       pending_r;
    logic [NIBBLE_W-1:0]        nibble_s;
    logic [DIGITS-1:0]          digit_n_s;

    seven_seg_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .count (pre_s),
        .tick  (tick_s)
    );

    assign boundary_s = tick_s && (idx_r == LAST_IDX);
    assign guard_s    = (pre_s < PRE_W'(GUARD_CYCLES));

    // Digit index advances on every prescaler tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= digit_idx_t'(0);
        end else if (tick_s) begin
            idx_r <= next_idx(idx_r, LAST_IDX);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Shadow/active value handoff; a load in the boundary cycle bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r  <= {(NIBBLE_W*DIGITS){1'b0}};
            shadow_r  <= {(NIBBLE_W*DIGITS){1'b0}};
            pending_r <= 1'b0;
        end else if (load_i && boundary_s) begin
            active_r  <= value_i;
            shadow_r  <= value_i;
            pending_r <= 1'b0;
        end else if (load_i) begin
            shadow_r  <= value_i;
            pending_r <= 1'b1;
        end else if (boundary_s && pending_r) begin
            active_r  <= shadow_r;
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Digit select and enable decode, driven purely from registered state
    always_comb begin : out_decode
        logic [NIBBLE_W-1:0] nib;
        logic                blank;
`ifdef SEVEN_SEG_SCANNER_BLANK_LEADING_ZEROS_EN
        logic                upper_zero;
        upper_zero = 1'b1;
`endif
        nibble_s  = 4'h0;
        digit_n_s = {DIGITS{1'b1}};
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = active_r[NIBBLE_W*k +: NIBBLE_W];
`ifdef SEVEN_SEG_SCANNER_BLANK_LEADING_ZEROS_EN
            upper_zero = upper_zero && (nib == 4'h0);
            blank      = upper_zero && (k != 0);
`else
            blank      = 1'b0;
`endif
            if (idx_r == digit_idx_t'(k)) begin
                nibble_s     = nib;
                digit_n_s[k] = guard_s || blank;
            end else begin
                digit_n_s[k] = 1'b1;
            end
        end
    end

    assign nibble_o  = nibble_s;
    assign digit_n_o = digit_n_s;
    assign frame_o   = boundary_s;
    assign pending_o = pending_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: cycle-indexed reference model vs DUT outputs.
module tb_seven_seg_scanner;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int GUARD  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] value_i = 16'h0000;
    logic        pending_o;
    logic [3:0]  nibble_o;
    logic [3:0]  digit_n_o;
    logic        frame_o;

    seven_seg_scanner #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (DIV),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value_i   (value_i),
        .load_i    (load_i),
        .pending_o (pending_o),
        .nibble_o  (nibble_o),
        .digit_n_o (digit_n_o),
        .frame_o   (frame_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  dn;
        logic [3:0]  nib;
        logic        fr;
        logic        pend;
    } exp_t;

    exp_t        exp_q[$];
    event        sample_ev;
    int          tests_run = 0;
    int          failed = 0;
    int          t = 0;
    bit          done = 1'b0;
    logic [15:0] disp = 16'h0000;
    logic [15:0] pv = 16'h0000;
    logic        pend = 1'b0;

    // Expected outputs for cycle tt of the scan, from slot arithmetic
    function automatic exp_t model_out(input int tt, input logic [15:0] d, input logic p);
        exp_t        e;
        int          slot;
        int          phase;
        logic        blank;
        logic [15:0] upper;
        slot  = (tt / DIV) % DIGITS;
        phase = tt % DIV;
        upper = d >> (4 * slot);
        blank = 1'b0;
`ifdef SEVEN_SEG_SCANNER_BLANK_LEADING_ZEROS_EN
        blank = (slot > 0) && (upper == 16'h0000);
`endif
        e.cyc  = tt;
        e.nib  = upper[3:0];
        e.dn   = (phase < GUARD || blank) ? 4'hF : ~(4'b0001 << slot);
        e.fr   = ((tt % FRAME) == FRAME - 1);
        e.pend = p;
        return e;
    endfunction

    // Monitor: pops one expectation per sample point and compares
    always begin
        exp_t e;
        @(negedge clk or sample_ev);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if ({digit_n_o, nibble_o, frame_o, pending_o} !== {e.dn, e.nib, e.fr, e.pend}) begin
                failed++;
                $display("FAIL scan cyc=%0d: got dn=%b nib=%h fr=%b pend=%b, expected dn=%b nib=%h fr=%b pend=%b",
                         $signed(e.cyc), digit_n_o, nibble_o, frame_o, pending_o, e.dn, e.nib, e.fr, e.pend);
            end
        end
    end

    // Watchdog: the stimulus must complete within a bounded number of cycles
    initial begin
        repeat (40 * FRAME) @(posedge clk);
        tests_run++;
        if (!done) begin
            failed++;
            $display("FAIL timeout: stimulus did not complete within %0d cycles", 40 * FRAME);
            $display("[TB] %0d tests run, %0d failed", tests_run, failed);
            $finish;
        end
    end

    task automatic model_reset();
        t    = 0;
        disp = 16'h0000;
        pv   = 16'h0000;
        pend = 1'b0;
    endtask

    // One clock cycle: queue expectation, drive inputs, advance the model
    task automatic cycle(input logic ld, input logic [15:0] v);
        logic boundary;
        exp_q.push_back(model_out(t, disp, pend));
        load_i  = ld;
        value_i = v;
        @(posedge clk);
        #1;
        boundary = ((t % FRAME) == FRAME - 1);
        if (ld && boundary) begin
            disp = v;
            pend = 1'b0;
        end else if (ld) begin
            pv   = v;
            pend = 1'b1;
        end else if (boundary && pend) begin
            disp = pv;
            pend = 1'b0;
        end
        t++;
        load_i = 1'b0;
    endtask

    task automatic check_reset_now();
        tests_run++;
        if ({digit_n_o, nibble_o, frame_o, pending_o} !== {4'hF, 4'h0, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL reset at %0t: got dn=%b nib=%h fr=%b pend=%b, expected dn=1111 nib=0 fr=0 pend=0",
                     $time, digit_n_o, nibble_o, frame_o, pending_o);
        end
        #1;
    endtask

    initial begin
        logic        ld;
        logic [15:0] v;
        #12;
        check_reset_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Frame 0: load mid-frame; frame 1: two loads, last wins
        while (t < 2 * FRAME) begin
            if (t == 5)            cycle(1'b1, 16'h12AF);
            else if (t == 32 + 3)  cycle(1'b1, 16'h1111);
            else if (t == 32 + 10) cycle(1'b1, 16'h2222);
            else                   cycle(1'b0, 16'h0000);
        end
        // Frame 2: load exactly on the boundary cycle
        while (t < 3 * FRAME + 4) begin
            if (t == 3 * FRAME - 1) cycle(1'b1, 16'h000F);
            else                    cycle(1'b0, 16'h0000);
        end
        // Zero-heavy values exercise blanking; next frame shows 0050 then 0
        while ((t % FRAME) != 0) cycle(1'b0, 16'h0000);
        cycle(1'b1, 16'h0050);
        while ((t % FRAME) != 0) cycle(1'b0, 16'h0000);
        cycle(1'b1, 16'h0000);
        while ((t % FRAME) != 0) cycle(1'b0, 16'h0000);
        cycle(1'b0, 16'h0000);

        // Randomized loads, including boundary-coincident ones
        repeat (400) begin
            v  = 16'($urandom) >> (4 * $urandom_range(0, 3));
            ld = ($urandom_range(0, 9) == 0) ||
                 (((t % FRAME) == FRAME - 1) && ($urandom_range(0, 1) == 1));
            cycle(ld, v);
        end

        // Async reset mid-slot with a pending value that must be discarded
        while ((t % FRAME) != 0) cycle(1'b0, 16'h0000);
        cycle(1'b1, 16'hABCD);
        while ((t % FRAME) != 13) cycle(1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_now();
        @(posedge clk);
        #1;
        check_reset_now();
        rst_n = 1'b1;
        model_reset();
        repeat (FRAME + 8) cycle(1'b0, 16'h0000);

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for a multi-digit common-anode 7-segment display. Sits directly upstream of the existing hex-to-segment `decoder`. Each refresh slot selects one digit, presents that digit's nibble on `nibble_o` for the decoder, and drives exactly one active-low digit enable. New display values are taken through a shadow register and applied only at frame boundaries, so a frame never shows digits from two different values.

## Interface
- `DIGITS`, 4: number of digits, 2..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot, at least 4.
- `GUARD_CYCLES`, 2: cycles at the start of each slot with all digits off (anti-ghosting), less than REFRESH_DIV.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `value_i`  in  4*DIGITS  display value; nibble k is digit k; digit 0 is least significant (rightmost).
- `load_i`  in  1  single-cycle strobe; captures `value_i`.
- `pending_o`  out  1  a captured value is waiting for the next frame boundary.
- `nibble_o`  out  4  nibble of the current digit, feeds decoder switch input.
- `digit_n_o`  out  DIGITS  digit enables, active-low, at most one low.
- `frame_o`  out  1  one-cycle pulse on the frame wrap cycle.

## Operation
- State: prescaler `pre` (0..REFRESH_DIV-1), digit index `idx` (0..DIGITS-1), `active` and `shadow` value registers, and the `pending` flag.
- Reset values: pre=0, idx=0, active=0, shadow=0, pending=0. Outputs under reset: nibble_o=0, digit_n_o=all ones, frame_o=0, pending_o=0.
- Prescaler: `pre` increments each cycle. When pre==REFRESH_DIV-1 the cycle is a "tick": `pre` wraps to 0 and `idx` increments.
- Index wrap: on a tick with idx==DIGITS-1, `idx` wraps to 0 and the cycle is a "frame boundary". `frame_o`=1 in exactly that cycle.
- Load, no boundary: `shadow`<=value_i and pending<=1. A later load before the boundary overwrites `shadow`, so the last value wins.
- Boundary without load: if pending, then active<=shadow and pending<=0. Otherwise `active` is unchanged.
- Load coincident with a boundary: active<=value_i directly, shadow<=value_i, and pending<=0.
- Output `nibble_o` = active[4*idx+:4] at all times, including during guard cycles.
- Output `digit_n_o`: all ones while pre<GUARD_CYCLES. Otherwise only bit idx is low.
- Outputs depend only on registered state. There is no combinational path from inputs to outputs.

## Timing
- Slot length is REFRESH_DIV cycles. Frame length is DIGITS*REFRESH_DIV cycles.
- After reset release, digit 0 slot starts with pre=0. The first low on digit_n_o[0] is at cycle GUARD_CYCLES.
- Load-to-display latency: from 1 cycle (load in the boundary cycle is visible the next cycle) up to one full frame.
- `pending_o` rises the cycle after the load edge. It falls the cycle after the boundary.
- Reset mid-frame clears everything immediately, asynchronously. Any pending value is discarded.

## Configuration
- Macro `SEVEN_SEG_SCANNER_BLANK_LEADING_ZEROS_EN`.
- Defined: a digit k>0 is suppressed (digit_n_o stays all ones for its slot) when nibble k and all nibbles above it in `active` are 0. Digit 0 is never suppressed. Slot timing and frame_o are unchanged.
- Undefined: all digits are always shown.

## Structure
- Package `seven_seg_pkg` holds the segment/digit width constants (SEG_W=7, NIBBLE_W=4) and the digit-index type derived from the max DIGITS of 8. It is shared with the decoder.
- One sub-module, `seven_seg_prescaler`: a counter plus tick output parameterised by REFRESH_DIV. The scanner holds the index, value, and guard logic.

## Test plan
Run with DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2 unless noted.
- Reset scan: release reset with active=0. Cycles 0-1: digit_n_o=4'b1111. Cycles 2-7: 4'b1110, nibble_o=0. Cycle 8 starts digit 1. frame_o pulses at cycle 31.
- Load mid-frame: load_i with 16'h12AF at cycle 5. pending_o=1 from cycle 6 to cycle 31. From cycle 32: digit 0 shows nibble F, digit 1 A, digit 2 2, digit 3 1. The decoder then yields 7'b000_1110 for F and 7'b010_0100 for 2.
- Double load: 16'h1111 at cycle 3, then 16'h2222 at cycle 10. Only 2 is ever displayed after cycle 32.
- Coincident load: load_i with 16'h000F exactly in the frame_o cycle. The next cycle nibble_o=F and pending_o=0.
- Async reset mid-slot: assert rst_n low at cycle 13. In the same cycle, before any clock edge: digit_n_o=4'b1111, nibble_o=0, pending_o=0.
- With `SEVEN_SEG_SCANNER_BLANK_LEADING_ZEROS_EN`: active=16'h0050. Digit slots 2 and 3 keep digit_n_o=4'b1111. Digit 1 shows 5 and digit 0 shows 0. With active=0, only digit 0 lights.
